// File: rtl/apb4_master_arbiter.sv
// Two-requester round-robin APB4 master: grant -> SETUP -> ACCESS, response pulse one cycle after completion.
// Zero-wait latency grant+3; back-to-back one transfer per 2 cycles; req_ready pulses only at arbitration points.
module apb4_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [2*ADDR_WIDTH-1:0]       req_addr,
  input  logic [1:0]                    req_write,
  input  logic [2*DATA_WIDTH-1:0]       req_wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0]   req_strb,
  output logic [1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  output logic [DATA_WIDTH/8-1:0]       PSTRB,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    xfer_done;
  logic                    timeout_hit;
  logic                    arb_en;
  logic                    gnt_vld;
  logic                    gnt_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_write;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [STRB_W-1:0]       sel_strb;

  // A timeout can only arbitrate once the bus is idle again, so it is excluded from arb_en.
  always_comb begin
    xfer_done   = (state_q == ACCESS) && PREADY;
    timeout_hit = TMO_EN && (state_q == ACCESS) && !PREADY && (wait_cnt_q == TMO_LAST);
    arb_en      = !PRESET && ((state_q == IDLE) || xfer_done);
    gnt_vld     = arb_en && (req_valid != 2'b00);
    gnt_idx     = (&req_valid) ? ~last_grant_q : req_valid[1];
    req_ready   = 2'b00;
    if (gnt_vld) begin
      req_ready = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    sel_addr  = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    sel_write = gnt_idx ? req_write[1] : req_write[0];
    sel_wdata = gnt_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    sel_strb  = gnt_idx ? req_strb[2*STRB_W-1:STRB_W] : req_strb[STRB_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_rdata_d               = pwrite_q ? '0 : PRDATA;
          rsp_err_d                 = PSLVERR;
          state_d                   = IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_err_d                 = 1'b1;
          state_d                   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // last_grant_q still names the owner of the completing transfer above.
    if (gnt_vld) begin
      state_d      = SETUP;
      last_grant_d = gnt_idx;
      wait_cnt_d   = '0;
      paddr_d      = sel_addr;
      pwrite_d     = sel_write;
      pwdata_d     = sel_wdata;
      pstrb_d      = sel_write ? sel_strb : '0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// Scoreboard bench: requester driver pushes expected responses on grant, monitor pops on rsp_valid.
module tb_apb4_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } req_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } bus_t;

  logic               PCLK = 1'b0;
  logic               PRESET = 1'b1;
  logic [1:0]         req_valid = '0;
  logic [1:0]         req_ready;
  logic [2*AW-1:0]    req_addr = '0;
  logic [1:0]         req_write = '0;
  logic [2*DW-1:0]    req_wdata = '0;
  logic [2*SW-1:0]    req_strb = '0;
  logic [1:0]         rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               PSEL, PENABLE, PWRITE;
  logic [AW-1:0]      PADDR;
  logic [DW-1:0]      PWDATA;
  logic [SW-1:0]      PSTRB;
  logic [DW-1:0]      PRDATA = '0;
  logic               PREADY = 1'b0;
  logic               PSLVERR = 1'b0;

  apb4_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  req_t rq0[$];
  req_t rq1[$];
  rsp_t sb[$];
  bus_t bus_log[$];
  logic gnt_log[$];
  int   rsp_cyc[$];
  logic taken0 = 1'b0;
  logic taken1 = 1'b0;
  int   gnt_cyc = 0;
  int   setup_cyc = 0;
  int   access_cyc = 0;
  int   last_rsp_cyc = 0;
  logic rsp_psel = 1'b0;
  int   acc_n = 0;

  // Slave behaviour knobs
  int            slv_wait = 0;
  logic          slv_never = 1'b0;
  logic          slv_err = 1'b0;
  logic [DW-1:0] slv_rdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                              input logic [SW-1:0] s, input logic [DW-1:0] rd, input logic e);
    req_t r;
    r.addr = a; r.write = w; r.wdata = wd; r.strb = s; r.exp_rdata = rd; r.exp_err = e;
    return r;
  endfunction

  // Requester driver: presents queue heads, records grants and expected responses
  initial begin
    rsp_t e;
    forever begin
      @(negedge PCLK);
      if (taken0) begin rq0.delete(0); taken0 = 1'b0; end
      if (taken1) begin rq1.delete(0); taken1 = 1'b0; end
      if (rq0.size() > 0) begin
        req_valid[0]        = 1'b1;
        req_addr[AW-1:0]    = rq0[0].addr;
        req_write[0]        = rq0[0].write;
        req_wdata[DW-1:0]   = rq0[0].wdata;
        req_strb[SW-1:0]    = rq0[0].strb;
      end else begin
        req_valid[0] = 1'b0;
      end
      if (rq1.size() > 0) begin
        req_valid[1]          = 1'b1;
        req_addr[2*AW-1:AW]   = rq1[0].addr;
        req_write[1]          = rq1[0].write;
        req_wdata[2*DW-1:DW]  = rq1[0].wdata;
        req_strb[2*SW-1:SW]   = rq1[0].strb;
      end else begin
        req_valid[1] = 1'b0;
      end
      #1;
      if (req_ready[0]) begin
        if (rq0.size() > 0) begin
          taken0 = 1'b1;
          e.id = 1'b0; e.rdata = rq0[0].exp_rdata; e.err = rq0[0].exp_err;
          sb.push_back(e);
          gnt_log.push_back(1'b0);
          gnt_cyc = cyc;
        end else begin
          chk("ready0_without_valid", 1, 0);
        end
      end
      if (req_ready[1]) begin
        if (rq1.size() > 0) begin
          taken1 = 1'b1;
          e.id = 1'b1; e.rdata = rq1[0].exp_rdata; e.err = rq1[0].exp_err;
          sb.push_back(e);
          gnt_log.push_back(1'b1);
          gnt_cyc = cyc;
        end else begin
          chk("ready1_without_valid", 1, 0);
        end
      end
    end
  end

  // APB slave model
  initial begin
    bus_t b;
    forever begin
      @(negedge PCLK);
      PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
      if (PSEL && !PENABLE) begin
        acc_n = 0;
        setup_cyc = cyc;
        b.addr = PADDR; b.write = PWRITE; b.wdata = PWDATA; b.strb = PSTRB;
        bus_log.push_back(b);
      end else if (PSEL && PENABLE) begin
        if (acc_n == 0) access_cyc = cyc;
        if (!slv_never && acc_n == slv_wait) begin
          PREADY = 1'b1; PRDATA = slv_rdata; PSLVERR = slv_err;
        end
        acc_n++;
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge PCLK);
      if (rsp_valid != 2'b00) begin
        rsp_cyc.push_back(cyc);
        last_rsp_cyc = cyc;
        rsp_psel = PSEL;
        chk("rsp_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_id", rsp_valid, e.id ? 2'b10 : 2'b01);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  task automatic step();
    @(posedge PCLK);
    #2;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || sb.size() > 0 || PSEL) && n < 200) begin
      step();
      n++;
    end
    chk({nm, "_complete"}, (n < 200), 1);
    step();
  endtask

  initial begin
    int n;
    int run;
    // Reset state
    PRESET = 1'b1;
    repeat (3) step();
    chk("rst_ctrl", {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata_pstrb", {PWDATA, PSTRB}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rst_req_ready", req_ready, 2'b00);
    PRESET = 1'b0;
    step();

    // Contention: both requesters hold two requests each
    slv_wait = 0; slv_never = 1'b0; slv_err = 1'b0; slv_rdata = 32'h5A5A_0000;
    gnt_log.delete(); rsp_cyc.delete();
    rq0.push_back(mk(32'h100, 1'b1, 32'hA0, 4'hF, 32'h0, 1'b0));
    rq1.push_back(mk(32'h200, 1'b0, 32'h0, 4'h0, 32'h5A5A_0000, 1'b0));
    rq0.push_back(mk(32'h108, 1'b1, 32'hA1, 4'h3, 32'h0, 1'b0));
    rq1.push_back(mk(32'h208, 1'b0, 32'h0, 4'h0, 32'h5A5A_0000, 1'b0));
    n = 0;
    while (!PSEL && n < 20) begin step(); n++; end
    chk("cont_start", PSEL, 1'b1);
    run = 0;
    while (PSEL && run < 50) begin run++; step(); end
    chk("cont_psel_run", run, 8);
    wait_idle("cont");
    chk("cont_gnt_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4)
      chk("cont_gnt_order", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 4'b0101);
    chk("cont_rsp_count", rsp_cyc.size(), 4);
    for (int i = 1; i < rsp_cyc.size(); i++)
      chk("cont_rsp_spacing", rsp_cyc[i] - rsp_cyc[i-1], 2);

    // Single zero-wait write
    bus_log.delete();
    rq0.push_back(mk(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0));
    wait_idle("wr");
    chk("wr_setup_lat", setup_cyc - gnt_cyc, 1);
    chk("wr_access_lat", access_cyc - gnt_cyc, 2);
    chk("wr_rsp_lat", last_rsp_cyc - gnt_cyc, 3);
    chk("wr_bus_count", bus_log.size(), 1);
    if (bus_log.size() == 1)
      chk("wr_bus", {bus_log[0].addr, bus_log[0].write, bus_log[0].wdata[27:0], bus_log[0].strb},
          {32'h10, 1'b1, 28'hEAD_BEEF, 4'hF});

    // Read with three wait states; strobes forced to zero
    bus_log.delete();
    slv_wait = 3; slv_rdata = 32'h1234_5678;
    rq1.push_back(mk(32'h20, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b0));
    wait_idle("rd");
    chk("rd_access_cycles", acc_n, 4);
    chk("rd_rsp_lat", last_rsp_cyc - gnt_cyc, 6);
    if (bus_log.size() == 1)
      chk("rd_bus", {bus_log[0].addr, bus_log[0].write, bus_log[0].strb}, {32'h20, 1'b0, 4'h0});

    // Slave error on a write: rdata forced to zero
    slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'hBAD0_BAD0;
    rq0.push_back(mk(32'h30, 1'b1, 32'h55, 4'h1, 32'h0, 1'b1));
    wait_idle("err");
    slv_err = 1'b0;

    // Timeout then a normal transfer
    slv_never = 1'b1;
    rq1.push_back(mk(32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1));
    wait_idle("tmo");
    chk("tmo_access_cycles", acc_n, 16);
    chk("tmo_psel_at_rsp", rsp_psel, 1'b0);
    chk("tmo_rsp_lat", last_rsp_cyc - gnt_cyc, 18);
    slv_never = 1'b0; slv_rdata = 32'hCAFE_0001;
    rq1.push_back(mk(32'h44, 1'b0, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0));
    wait_idle("post_tmo");

    // Reset during a wait state, then contention after release
    slv_never = 1'b1;
    rq0.push_back(mk(32'h50, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0));
    n = 0;
    while (!(PSEL && PENABLE) && n < 20) begin step(); n++; end
    chk("rst_mid_in_access", PSEL && PENABLE, 1'b1);
    step(); step();
    PRESET = 1'b1;
    sb.delete();
    step();
    chk("rst_mid_bus", {PSEL, PENABLE}, 2'b00);
    chk("rst_mid_no_rsp", rsp_valid, 2'b00);
    slv_never = 1'b0; slv_rdata = 32'h0000_0077;
    gnt_log.delete();
    rq1.push_back(mk(32'h60, 1'b0, 32'h0, 4'h0, 32'h77, 1'b0));
    rq0.push_back(mk(32'h64, 1'b1, 32'h99, 4'hF, 32'h0, 1'b0));
    step();
    chk("rst_hold_req_ready", req_ready, 2'b00);
    PRESET = 1'b0;
    wait_idle("rst_after");
    chk("rst_gnt_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2)
      chk("rst_gnt_order", {gnt_log[0], gnt_log[1]}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
